noc_cfg_initiator: RTL and testbench

Per-processor configuration initiator for the 2x2 mesh. It queues path requests from the local processor and encodes each one into the 11-bit `pN_configure` word that the mesh consumes. It holds each word for a fixed window, then tracks the node's ready line through acceptance and completion, retrying when the path is blocked. One instance drives each of `p0_configure`..`p3_configure`, taking the place of hand-driven stimulus.

---
 rtl/noc_cfg_initiator_if.sv | 22 ++
 rtl/noc_cfg_initiator.sv | 131 +++++++++++++
 tb/tb_noc_cfg_initiator.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/noc_cfg_initiator_if.sv
// noc_cfg_initiator_if: request queue, configure word and mesh status for one initiator
interface noc_cfg_initiator_if;
    logic        req_valid;
    logic [1:0]  req_cmd;
    logic [6:0]  req_len;
    logic [1:0]  req_dest;
    logic        req_ready;
    logic [10:0] configure;
    logic        proc_ready;
    logic [4:0]  path_block;
    logic        done;
    logic [1:0]  status;
    logic        busy;
    modport master (
        input  req_valid, req_cmd, req_len, req_dest, proc_ready, path_block,
        output req_ready, configure, done, status, busy
    );
    modport slave (
        output req_valid, req_cmd, req_len, req_dest, proc_ready, path_block,
        input  req_ready, configure, done, status, busy
    );
endinterface

// File: rtl/noc_cfg_initiator.sv
// noc_cfg_initiator: queues path requests and drives one node's configure word with hold/ack/retry tracking
module noc_cfg_initiator #(
    parameter int FIFO_DEPTH     = 4,
    parameter int HOLD_CYCLES    = 3,
    parameter int ACK_TIMEOUT    = 16,
    parameter int DONE_TIMEOUT   = 256,
    parameter int BACKOFF_CYCLES = 8,
    parameter int MAX_RETRY      = 3
) (
    input logic clk,
    input logic rst_n,
    noc_cfg_initiator_if.master bus
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int T1   = ACK_TIMEOUT > DONE_TIMEOUT ? ACK_TIMEOUT : DONE_TIMEOUT;
    localparam int T2   = HOLD_CYCLES > BACKOFF_CYCLES ? HOLD_CYCLES : BACKOFF_CYCLES;
    localparam int TMAX = T1 > T2 ? T1 : T2;
    localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
    localparam int RW   = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, BACKOFF} state_t;

    state_t        state, state_n;
    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic [TW-1:0] timer, timer_n, timer_inc;
    logic [RW-1:0] retry, retry_n;
    logic [10:0]   cur, cur_n, cfg, cfg_n;
    logic          done_r, done_n;
    logic [1:0]    status_r, status_n;

    assign empty         = wr_ptr == rd_ptr;
    assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push          = bus.req_valid && !full;
    assign bus.req_ready = !full;
    assign bus.busy      = state != IDLE;
    assign bus.configure = cfg;
    assign bus.done      = done_r;
    assign bus.status    = status_r;
    assign timer_inc     = &timer ? timer : timer + 1'b1;

    always_comb begin
        state_n  = state;
        timer_n  = timer_inc;
        retry_n  = retry;
        cur_n    = cur;
        cfg_n    = cfg;
        done_n   = 1'b0;
        status_n = status_r;
        pop      = 1'b0;
        case (state)
            IDLE: if (!empty && bus.proc_ready) begin
                pop     = 1'b1;
                cur_n   = mem[rd_ptr[AW-1:0]];
                retry_n = '0;
                timer_n = '0;
                if (cur_n[10:9] == 2'b00) begin
                    done_n   = 1'b1;
                    status_n = 2'b11;
                end else begin
                    cfg_n   = cur_n;
                    state_n = ISSUE;
                end
            end
            ISSUE: if (timer == TW'(HOLD_CYCLES - 1)) begin
                cfg_n   = '0;
                timer_n = '0;
                state_n = WAIT_ACK;
            end
            WAIT_ACK: if (!bus.proc_ready) begin
                timer_n = '0;
                state_n = WAIT_DONE;
            end else if (|bus.path_block) begin
                timer_n = '0;
                state_n = BACKOFF;
            end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                done_n   = 1'b1;
                status_n = 2'b01;
                state_n  = IDLE;
            end
            WAIT_DONE: if (bus.proc_ready || timer == TW'(DONE_TIMEOUT - 1)) begin
                done_n   = 1'b1;
                status_n = bus.proc_ready ? 2'b00 : 2'b01;
                state_n  = IDLE;
            end
            BACKOFF: if (timer == TW'(BACKOFF_CYCLES - 1)) begin
                if (retry < RW'(MAX_RETRY)) begin
                    retry_n = retry + 1'b1;
                    cfg_n   = cur;
                    timer_n = '0;
                    state_n = ISSUE;
                end else begin
                    done_n   = 1'b1;
                    status_n = 2'b10;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            retry    <= '0;
            cur      <= '0;
            cfg      <= '0;
            done_r   <= 1'b0;
            status_r <= 2'b00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            retry    <= retry_n;
            cur      <= cur_n;
            cfg      <= cfg_n;
            done_r   <= done_n;
            status_r <= status_n;
            wr_ptr   <= wr_ptr + (AW+1)'(push);
            rd_ptr   <= rd_ptr + (AW+1)'(pop);
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {bus.req_cmd, bus.req_len, bus.req_dest};
    end
endmodule

// File: tb/tb_noc_cfg_initiator.sv
// tb_noc_cfg_initiator: directed self-checking bench for noc_cfg_initiator
module tb_noc_cfg_initiator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    noc_cfg_initiator_if bus();
    noc_cfg_initiator dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic [1:0] c, input logic [6:0] l, input logic [1:0] d);
        bus.req_valid = v;
        bus.req_cmd   = c;
        bus.req_len   = l;
        bus.req_dest  = d;
    endtask

    logic [10:0] w [4];
    logic [1:0]  cmds [4];

    initial begin
        set_req(1'b0, 2'b00, 7'd0, 2'd0);
        bus.proc_ready = 1'b1;
        bus.path_block = 5'b0;
        tick(2);
        chk("rst_configure", 32'(bus.configure), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_status", 32'(bus.status), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        rst_n = 1'b1;
        tick(1);

        // basic setup transaction
        set_req(1'b1, 2'b01, 7'd1, 2'd1);
        tick(1);
        set_req(1'b0, 2'b00, 7'd0, 2'd0);
        chk("t1_push_cfg", 32'(bus.configure), 32'h0);
        tick(1);
        chk("t1_cfg_a", 32'(bus.configure), 32'b01000000101);
        chk("t1_busy", 32'(bus.busy), 32'h1);
        tick(1);
        chk("t1_cfg_b", 32'(bus.configure), 32'b01000000101);
        tick(1);
        chk("t1_cfg_c", 32'(bus.configure), 32'b01000000101);
        tick(1);
        chk("t1_release", 32'(bus.configure), 32'h0);
        bus.proc_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t1_no_done", 32'(bus.done), 32'h0);
        end
        bus.proc_ready = 1'b1;
        tick(1);
        chk("t1_done", 32'(bus.done), 32'h1);
        chk("t1_status", 32'(bus.status), 32'h0);
        tick(1);
        chk("t1_done_pulse", 32'(bus.done), 32'h0);
        chk("t1_idle", 32'(bus.busy), 32'h0);

        // fill the queue while the node is busy
        cmds[0] = 2'b01; cmds[1] = 2'b10; cmds[2] = 2'b11; cmds[3] = 2'b01;
        w[0] = 11'b01_0000010_00;
        w[1] = 11'b10_0000011_01;
        w[2] = 11'b11_0000100_10;
        w[3] = 11'b01_0000101_11;
        bus.proc_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, cmds[i % 4], 7'(i + 2), 2'(i));
            chk("t2_req_ready", 32'(bus.req_ready), (i < 4) ? 32'h1 : 32'h0);
            tick(1);
        end
        set_req(1'b0, 2'b00, 7'd0, 2'd0);
        chk("t2_still_idle", 32'(bus.busy), 32'h0);
        bus.proc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("t2_word", 32'(bus.configure), 32'(w[i]));
            tick(2);
            chk("t2_word_hold", 32'(bus.configure), 32'(w[i]));
            tick(1);
            chk("t2_release", 32'(bus.configure), 32'h0);
            bus.proc_ready = 1'b0;
            tick(1);
            bus.proc_ready = 1'b1;
            tick(1);
            chk("t2_done", 32'(bus.done), 32'h1);
            chk("t2_status", 32'(bus.status), 32'h0);
        end
        tick(2);
        chk("t2_drained", 32'(bus.busy), 32'h0);
        chk("t2_no_fifth", 32'(bus.configure), 32'h0);

        // blocked path: four attempts then retries exhausted
        bus.path_block = 5'b00100;
        set_req(1'b1, 2'b01, 7'h7f, 2'd3);
        tick(1);
        set_req(1'b0, 2'b00, 7'd0, 2'd0);
        tick(1);
        for (int a = 0; a < 4; a++) begin
            chk("t3_issue", 32'(bus.configure), 32'h3ff);
            tick(2);
            chk("t3_hold", 32'(bus.configure), 32'h3ff);
            tick(1);
            chk("t3_release", 32'(bus.configure), 32'h0);
            tick(8);
            chk("t3_backoff_cfg", 32'(bus.configure), 32'h0);
            chk("t3_backoff_done", 32'(bus.done), 32'h0);
            tick(1);
            if (a < 3) chk("t3_retry_cfg", 32'(bus.configure), 32'h3ff);
        end
        chk("t3_done", 32'(bus.done), 32'h1);
        chk("t3_status", 32'(bus.status), 32'h2);
        chk("t3_cfg_idle", 32'(bus.configure), 32'h0);
        tick(1);
        chk("t3_idle", 32'(bus.busy), 32'h0);
        bus.path_block = 5'b0;

        // ack timeout, then a following request still issues
        set_req(1'b1, 2'b10, 7'd9, 2'd2);
        tick(1);
        set_req(1'b0, 2'b00, 7'd0, 2'd0);
        tick(1);
        chk("t4_issue", 32'(bus.configure), 32'b10_0001001_10);
        tick(3);
        chk("t4_release", 32'(bus.configure), 32'h0);
        tick(15);
        chk("t4_no_done_yet", 32'(bus.done), 32'h0);
        tick(1);
        chk("t4_done", 32'(bus.done), 32'h1);
        chk("t4_status", 32'(bus.status), 32'h1);
        set_req(1'b1, 2'b01, 7'd3, 2'd0);
        tick(1);
        set_req(1'b0, 2'b00, 7'd0, 2'd0);
        chk("t4_status_held", 32'(bus.status), 32'h1);
        tick(1);
        chk("t4_next_issue", 32'(bus.configure), 32'b01_0000011_00);
        tick(3);
        bus.proc_ready = 1'b0;
        tick(1);
        bus.proc_ready = 1'b1;
        tick(1);
        chk("t4_next_done", 32'(bus.done), 32'h1);
        chk("t4_next_status", 32'(bus.status), 32'h0);

        // illegal command
        set_req(1'b1, 2'b00, 7'd5, 2'd2);
        tick(1);
        set_req(1'b0, 2'b00, 7'd0, 2'd0);
        chk("t5_push_done", 32'(bus.done), 32'h0);
        tick(1);
        chk("t5_done", 32'(bus.done), 32'h1);
        chk("t5_status", 32'(bus.status), 32'h3);
        chk("t5_cfg", 32'(bus.configure), 32'h0);
        chk("t5_busy", 32'(bus.busy), 32'h0);
        tick(1);
        chk("t5_done_pulse", 32'(bus.done), 32'h0);
        chk("t5_cfg_after", 32'(bus.configure), 32'h0);

        // asynchronous reset mid-issue with a request still queued
        set_req(1'b1, 2'b01, 7'd20, 2'd1);
        tick(1);
        set_req(1'b1, 2'b01, 7'd21, 2'd2);
        tick(1);
        set_req(1'b0, 2'b00, 7'd0, 2'd0);
        chk("t6_issue", 32'(bus.configure), 32'b01_0010100_01);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_cfg", 32'(bus.configure), 32'h0);
        chk("t6_async_busy", 32'(bus.busy), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        chk("t6_cfg_after", 32'(bus.configure), 32'h0);
        chk("t6_busy_after", 32'(bus.busy), 32'h0);
        chk("t6_req_ready", 32'(bus.req_ready), 32'h1);
        chk("t6_done_after", 32'(bus.done), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
